// File: rtl/lru_executor.sv
// Mode executor for the board controller: cycle counter, LRU table access/insert and LRU readout.
// Optional hit/miss statistics are built when LRU_EXEC_STATS_EN is defined.
module lru_executor #(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        state_i,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [15:0]       result_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       stats_o
);

    localparam int unsigned AW = $clog2(WAYS);

    typedef enum logic [1:0] {StIdle, StSearch, StUpdate} fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic              set_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic              rd_mode_q;
    logic [DATA_W-1:0] key_q, key_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              hit_q, hit_d;
    logic [AW-1:0]     hit_way_q, hit_way_d;
    logic              valid_q [WAYS];
    logic              valid_d [WAYS];
    logic [DATA_W-1:0] keys_q [WAYS];
    logic [DATA_W-1:0] keys_d [WAYS];
    logic [AW-1:0]     age_q [WAYS];
    logic [AW-1:0]     age_d [WAYS];
    logic [15:0]       result_q, result_d;

    logic          clear;
    logic          set_pulse;
    logic          mode_cnt, mode_wr, mode_rd;
    logic          rd_entry;
    logic [AW-1:0] rd_eff;
    logic [AW-1:0] rd_way;
    logic [AW-1:0] tgt_way;
    logic [AW-1:0] tgt_age;
    logic          found_inv;

    assign clear     = rst_i | clr_i;
    assign set_pulse = set_i & ~set_q;
    assign mode_cnt  = (state_i == 3'b100);
    assign mode_wr   = (state_i == 3'b010);
    assign mode_rd   = (state_i == 3'b001);

    // Readout restarts from MRU whenever LRU_RD is freshly entered.
    assign rd_entry = mode_rd & ~rd_mode_q;
    assign rd_eff   = rd_entry ? '0 : rd_idx_q;

    always_comb begin
        rd_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[w] == rd_eff) rd_way = AW'(w);
        end
    end

    // Replacement target: hit way, else lowest invalid way, else the LRU way.
    always_comb begin
        tgt_way   = '0;
        found_inv = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_q[w] && !found_inv) begin
                found_inv = 1'b1;
                tgt_way   = AW'(w);
            end
        end
        if (!found_inv) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[w] == AW'(WAYS - 1)) tgt_way = AW'(w);
            end
        end
        if (hit_q) tgt_way = hit_way_q;
        tgt_age = age_q[tgt_way];
    end

    always_comb begin
        fsm_d     = fsm_q;
        key_d     = key_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        hit_way_d = hit_way_q;
        valid_d   = valid_q;
        keys_d    = keys_q;
        age_d     = age_q;
        unique case (fsm_q)
            StIdle: begin
                if (mode_wr && set_pulse) begin
                    fsm_d     = StSearch;
                    key_d     = data_i;
                    idx_d     = '0;
                    hit_d     = 1'b0;
                    hit_way_d = '0;
                end
            end
            StSearch: begin
                if (valid_q[idx_q] && (keys_q[idx_q] == key_q)) begin
                    hit_d     = 1'b1;
                    hit_way_d = idx_q;
                end
                if (idx_q == AW'(WAYS - 1)) begin
                    fsm_d = StUpdate;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            StUpdate: begin
                fsm_d = StIdle;
                if (!hit_q) begin
                    valid_d[tgt_way] = 1'b1;
                    keys_d[tgt_way]  = key_q;
                end
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (AW'(w) == tgt_way) begin
                        age_d[w] = '0;
                    end else if (age_q[w] < tgt_age) begin
                        age_d[w] = age_q[w] + AW'(1);
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d    = mode_cnt ? cnt_q + CNT_W'(1) : cnt_q;
        rd_idx_d = rd_eff;
        if (mode_rd && set_pulse) rd_idx_d = rd_eff + AW'(1);
        result_d = result_q;
        if (fsm_q == StUpdate) begin
            result_d = {3'b000, hit_q, 4'(tgt_way), 8'(key_q)};
        end else if (mode_cnt) begin
            result_d = cnt_d[15:0];
        end else if (mode_rd && set_pulse) begin
            result_d = {2'b00, valid_q[rd_way], 1'b0, 4'(rd_way), 8'(keys_q[rd_way])};
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            fsm_q     <= StIdle;
            set_q     <= 1'b0;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            rd_mode_q <= 1'b0;
            key_q     <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            result_q  <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= 1'b0;
                keys_q[w]  <= '0;
                age_q[w]   <= AW'(w);
            end
        end else begin
            fsm_q     <= fsm_d;
            set_q     <= set_i;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            rd_mode_q <= mode_rd;
            key_q     <= key_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            hit_way_q <= hit_way_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            keys_q    <= keys_d;
            age_q     <= age_d;
        end
    end

    assign result_o = result_q;
    assign busy_o   = (fsm_q != StIdle);
    assign done_o   = (fsm_q == StUpdate);

`ifdef LRU_EXEC_STATS_EN
    logic [7:0] hit_cnt_q, hit_cnt_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (fsm_q == StUpdate) begin
            if (hit_q) begin
                if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
            end else begin
                if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign stats_o = {hit_cnt_q, miss_cnt_q};
`else
    assign stats_o = 16'h0000;
`endif

endmodule

// File: tb/tb_lru_executor.sv
// Directed bench for lru_executor: vector table for LRU ops plus hand sequences for corner cases.
module tb_lru_executor;

    localparam int unsigned WAYS   = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int          LAT    = WAYS + 1;
`ifdef LRU_EXEC_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [2:0]        state_i = 3'b000;
    logic              set_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic [15:0]       result_o;
    logic              busy_o;
    logic              done_o;
    logic [15:0]       stats_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  state;
        logic [7:0]  data;
        logic [15:0] exp_result;
        logic [15:0] exp_stats;
        logic        chk_stats;
    } vec_t;

    vec_t vecs [11];

    lru_executor #(
        .WAYS   (WAYS),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .state_i  (state_i),
        .set_i    (set_i),
        .clr_i    (clr_i),
        .data_i   (data_i),
        .result_o (result_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .stats_o  (stats_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_wr(input vec_t v, input int id);
        int busy_n;
        int done_at;
        state_i = v.state;
        data_i  = v.data[DATA_W-1:0];
        set_i   = 1'b1;
        tick();
        set_i   = 1'b0;
        busy_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 12; k++) begin
            if (busy_o) busy_n++;
            if (done_o && done_at == 0) done_at = k;
            tick();
        end
        check($sformatf("v%0d busy_len", id), busy_n, LAT);
        check($sformatf("v%0d done_at", id), done_at, LAT);
        check($sformatf("v%0d result", id), {16'h0, result_o}, {16'h0, v.exp_result});
        if (v.chk_stats)
            check($sformatf("v%0d stats", id), {16'h0, stats_o},
                  {16'h0, (StatsEn ? v.exp_stats : 16'h0000)});
    endtask

    task automatic run_rd(input vec_t v, input int id);
        state_i = v.state;
        set_i   = 1'b1;
        tick();
        check($sformatf("v%0d rd_result", id), {16'h0, result_o}, {16'h0, v.exp_result});
        set_i = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dones;
        int busy_seen;

        vecs[0]  = '{3'b010, 8'h1, 16'h0001, 16'h0001, 1'b1};
        vecs[1]  = '{3'b010, 8'h2, 16'h0102, 16'h0002, 1'b1};
        vecs[2]  = '{3'b010, 8'h3, 16'h0203, 16'h0003, 1'b1};
        vecs[3]  = '{3'b010, 8'h4, 16'h0304, 16'h0004, 1'b1};
        vecs[4]  = '{3'b010, 8'h2, 16'h1102, 16'h0104, 1'b1};
        vecs[5]  = '{3'b010, 8'h5, 16'h0005, 16'h0105, 1'b1};
        vecs[6]  = '{3'b001, 8'h0, 16'h2005, 16'h0000, 1'b0};
        vecs[7]  = '{3'b001, 8'h0, 16'h2102, 16'h0000, 1'b0};
        vecs[8]  = '{3'b001, 8'h0, 16'h2304, 16'h0000, 1'b0};
        vecs[9]  = '{3'b001, 8'h0, 16'h2203, 16'h0000, 1'b0};
        vecs[10] = '{3'b001, 8'h0, 16'h2005, 16'h0000, 1'b0};

        repeat (3) tick();
        rst_i = 1'b0;
        check("reset result", {16'h0, result_o}, 32'h0);
        check("reset busy", {31'h0, busy_o}, 32'h0);
        check("reset done", {31'h0, done_o}, 32'h0);
        check("reset stats", {16'h0, stats_o}, 32'h0);

        state_i = 3'b100;
        repeat (10) tick();
        check("cnt 10", {16'h0, result_o}, 32'h000A);
        state_i = 3'b010;
        repeat (5) tick();
        check("cnt hold", {16'h0, result_o}, 32'h000A);
        state_i = 3'b100;
        tick();
        check("cnt frozen", {16'h0, result_o}, 32'h000B);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].state == 3'b010) run_wr(vecs[i], i);
            else run_rd(vecs[i], i);
        end

        // Held button: one operation only (hit on key 5, way 0).
        state_i = 3'b010;
        data_i  = 4'h5;
        set_i   = 1'b1;
        dones   = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_o) dones++;
        end
        set_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_o) dones++;
        end
        check("hold dones", dones, 1);
        check("hold result", {16'h0, result_o}, 32'h1005);

        // Second pulse while busy is dropped; key 6 evicts LRU way 2.
        data_i = 4'h6;
        set_i  = 1'b1;
        dones  = 0;
        tick();
        if (done_o) dones++;
        set_i = 1'b0;
        tick();
        if (done_o) dones++;
        data_i = 4'h7;
        set_i  = 1'b1;
        tick();
        if (done_o) dones++;
        set_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done_o) dones++;
        end
        check("drop dones", dones, 1);
        check("drop result", {16'h0, result_o}, 32'h0206);

        // Invalid mode word ignores the pulse.
        state_i   = 3'b011;
        set_i     = 1'b1;
        busy_seen = 0;
        dones     = 0;
        tick();
        set_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy_o) busy_seen++;
            if (done_o) dones++;
            tick();
        end
        check("inv busy", busy_seen, 0);
        check("inv done", dones, 0);
        check("inv result", {16'h0, result_o}, 32'h0206);

        // Clear in the middle of SEARCH.
        state_i = 3'b010;
        data_i  = 4'h9;
        set_i   = 1'b1;
        tick();
        set_i = 1'b0;
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr busy", {31'h0, busy_o}, 32'h0);
        check("clr result", {16'h0, result_o}, 32'h0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done_o) dones++;
            tick();
        end
        check("clr done", dones, 0);
        check("clr stats", {16'h0, stats_o}, 32'h0);
        for (int w = 0; w < int'(WAYS); w++) begin
            vec_t rv;
            rv = '{3'b001, 8'h0, 16'(w << 8), 16'h0000, 1'b0};
            run_rd(rv, 100 + w);
        end
        state_i = 3'b100;
        repeat (3) tick();
        check("cnt restart", {16'h0, result_o}, 32'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lru_executor.md
Name: lru_executor

Overview:
- Consumer-side datapath for the board mode controller: takes the one-hot mode word, the raw set button level and the clear strobe, and executes the selected mode.
- Modes:
  - CNT_EN (3'b100): free-running cycle counter.
  - LRU_WR (3'b010): access or insert a switch-supplied key into a fully associative LRU table.
  - LRU_RD (3'b001): step through table contents from MRU to LRU.
- result_o feeds the seven-segment display driver.

Parameters:
- WAYS, 4, number of LRU entries (power of two, 2..8).
- DATA_W, 4, key width from switches (1..8).
- CNT_W, 16, cycle counter width (16..32; low 16 bits displayed).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- state_i  in  3  one-hot mode {CNT_EN, LRU_WR, LRU_RD}
- set_i  in  1  raw set button level; rising edge triggers an operation
- clr_i  in  1  synchronous clear strobe, same effect as rst_i
- data_i  in  DATA_W  key from switches
- result_o  out  16  display value
- busy_o  out  1  LRU_WR operation in progress
- done_o  out  1  one-cycle pulse when an LRU_WR operation commits
- stats_o  out  16  hit/miss statistics (see Optional Feature)

Behaviour:
- Reset and clear (rst_i or clr_i) return every register to its reset value:
  - set_q=0, counter=0, rd_idx=0, FSM=IDLE.
  - All entries invalid, keys=0, age[w]=w.
  - result_o=0, busy_o=0, done_o=0.
- Clear priority: clears take effect even mid-operation and override set pulses in the same cycle.
- Edge detect: set_q is registered from set_i; set_pulse = set_i & ~set_q. A held button yields exactly one pulse.
- Invalid state_i (not exactly one bit set): counter holds, set_pulse is ignored, result_o holds, and any in-flight operation still completes.
- CNT_EN:
  - Counter increments by 1 every cycle, wrapping at 2^CNT_W. It holds in all other modes.
  - result_o = counter[15:0]. set_pulse has no effect.
- Ages: each way has an age of log2(WAYS) bits. 0 = MRU, WAYS-1 = LRU. The ages always form a permutation of 0..WAYS-1.
- LRU_WR FSM (IDLE, SEARCH, UPDATE):
  - IDLE: on set_pulse, latch key=data_i, set idx=0, go to SEARCH. busy_o=1 from the next cycle.
  - SEARCH: compare way idx, one way per cycle. Record hit/hit_way on a valid key match. All WAYS ways are always scanned, giving fixed latency. Go to UPDATE after idx==WAYS-1.
  - UPDATE:
    - Target way: hit_way on a hit. On a miss, the lowest-index invalid way if one exists, otherwise the way with age WAYS-1.
    - On a miss, write key and valid=1 into the target way.
    - Age update with a = old age of the target: every way with age < a increments; the target becomes 0.
    - done_o=1 for this cycle; next state is IDLE; busy_o falls the following cycle.
  - Latency: busy_o is high for WAYS+1 cycles. done_o fires WAYS+1 cycles after the set_pulse cycle.
  - set_pulse while busy is dropped, not queued.
  - A mode change mid-operation lets the operation finish.
  - result_o after done: [15:13]=0, [12]=hit, [11:8]=target way, [7:0]=key zero-extended.
- LRU_RD:
  - Each set_pulse shows the entry whose age==rd_idx, then increments rd_idx mod WAYS.
  - result_o: [13]=entry valid, [12]=0, [11:8]=way, [7:0]=key zero-extended.
  - rd_idx resets to 0 on entering LRU_RD from another mode.

Optional Feature:
- Macro: LRU_EXEC_STATS_EN.
- Defined:
  - 8-bit saturating hit_cnt and miss_cnt (saturate at 255), updated in UPDATE, cleared by rst_i/clr_i.
  - stats_o = {hit_cnt, miss_cnt}.
- Undefined: stats_o is tied to 16'h0000 and no counters are synthesised.

Test Plan:
- Reset, state_i=100 for 10 cycles -> result_o=16'h000A; switch to 010 -> result_o holds, counter frozen at 10.
- state_i=010, insert keys 1,2,3,4 one pulse each:
  - Each completes as a miss, busy_o high 5 cycles, done_o pulse 5 cycles after the pulse.
  - Ways 0..3 hold 1,2,3,4; last result_o=16'h0304.
- Access key 2 -> result_o=16'h1102 (hit, way 1). Insert key 5 -> miss, victim way 0 (key 1), result_o=16'h0005. With LRU_EXEC_STATS_EN: stats_o=16'h0105.
- state_i=001, five set pulses -> keys 5,2,4,3, then 5 again (wrap); result_o[13]=1 on each.
- Hold set_i high for 20 cycles in LRU_WR -> exactly one done_o pulse. Pulse during busy -> dropped. state_i=011 with a pulse -> no operation, result_o unchanged.
- Assert clr_i during SEARCH -> next cycle busy_o=0, no done_o pulse, LRU_RD shows result_o[13]=0 for all ways, CNT_EN restarts from 0.
